msxbus_initiator: RTL and testbench

MSXBUS_INITIATOR -- requirements
Module: msxbus_initiator

---
 rtl/msxbus_pkg.sv | 17 +
 rtl/msxbus_initiator_if.sv | 34 +++
 rtl/msxbus_strobe_timer.sv | 30 +++
 rtl/msxbus_initiator.sv | 131 +++++++++++++
 tb/tb_msxbus_initiator.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msxbus_pkg.sv
// Shared types and constants for the MSX bus initiator.
package msxbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_SUB_SETUP,
        ST_SUB_STROBE,
        ST_SUB_HOLD
    } state_t;

    localparam logic [15:0] SUBSLOT_ADDR_DEFAULT = 16'hFFFF;
    localparam logic [7:0]  BUS_IDLE             = 8'hFF;

endpackage

// File: rtl/msxbus_initiator_if.sv
// Host request/response and MSX bus signals of the initiator.
interface msxbus_initiator_if;

    logic        req;
    logic        req_wr;
    logic        req_ext;
    logic [15:0] req_address;
    logic [7:0]  req_wdata;
    logic [7:0]  req_subslot;
    logic        ready;
    logic        done;
    logic [7:0]  rdata_out;
    logic        n_tsltsl;
    logic        n_trd;
    logic        n_twr;
    logic [15:0] ta;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_en;
    logic        n_wait;

    modport master (
        input  req, req_wr, req_ext, req_address, req_wdata, req_subslot,
        input  rdata, rdata_en, n_wait,
        output ready, done, rdata_out, n_tsltsl, n_trd, n_twr, ta, wdata
    );

    modport slave (
        output req, req_wr, req_ext, req_address, req_wdata, req_subslot,
        output rdata, rdata_en, n_wait,
        input  ready, done, rdata_out, n_tsltsl, n_trd, n_twr, ta, wdata
    );

endinterface

// File: rtl/msxbus_strobe_timer.sv
// Strobe-phase length counter; holds on its last count while n_wait is low.
module msxbus_strobe_timer #(
    parameter int unsigned STROBE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic active,
    input  logic n_wait,
    output logic last
);

    localparam logic [3:0] LAST_COUNT = 4'(STROBE_CYCLES - 1);

    logic [3:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (active && (count != LAST_COUNT)) begin
            count <= count + 4'd1;
        end
    end

    // n_wait only matters once the minimum length has been reached
    assign last = active && (count == LAST_COUNT) && n_wait;

endmodule

// File: rtl/msxbus_initiator.sv
// MSX cartridge-bus initiator: one host request becomes one bus cycle,
// optionally preceded by a secondary-slot register write.
module msxbus_initiator
    import msxbus_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 3,
    parameter logic [15:0] SUBSLOT_ADDR  = SUBSLOT_ADDR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    msxbus_initiator_if.master bus
);

    state_t      state, state_n;
    logic        accept;
    logic        last;
    logic        wr_q, wr_n;
    logic [15:0] addr_q, addr_n;
    logic [7:0]  data_q, data_n;
    logic [7:0]  sub_q, sub_n;
    logic [15:0] ta_q, ta_n;
    logic [7:0]  wdata_q, wdata_n;
    logic [7:0]  rdata_out_q;
    logic        ready_q, done_q;
    logic        n_tsltsl_q, n_trd_q, n_twr_q;

    msxbus_strobe_timer #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   ((state == ST_SETUP) || (state == ST_SUB_SETUP)),
        .active ((state == ST_STROBE) || (state == ST_SUB_STROBE)),
        .n_wait (bus.n_wait),
        .last   (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req && ready_q) begin
                    accept  = 1'b1;
                    state_n = bus.req_ext ? ST_SUB_SETUP : ST_SETUP;
                end
            end
            ST_SETUP:      state_n = ST_STROBE;
            ST_STROBE:     if (last) state_n = ST_HOLD;
            ST_HOLD:       state_n = ST_IDLE;
            ST_SUB_SETUP:  state_n = ST_SUB_STROBE;
            ST_SUB_STROBE: if (last) state_n = ST_SUB_HOLD;
            ST_SUB_HOLD:   state_n = ST_SETUP;
            default:       state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so the bus
    // pins change exactly on the edge that changes the state.
    always_comb begin
        wr_n    = accept ? bus.req_wr      : wr_q;
        addr_n  = accept ? bus.req_address : addr_q;
        data_n  = accept ? bus.req_wdata   : data_q;
        sub_n   = accept ? bus.req_subslot : sub_q;
        ta_n    = ta_q;
        wdata_n = wdata_q;
        case (state_n)
            ST_SUB_SETUP, ST_SUB_STROBE, ST_SUB_HOLD: begin
                ta_n    = SUBSLOT_ADDR;
                wdata_n = sub_n;
            end
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                ta_n = addr_n;
                if (wr_n) begin
                    wdata_n = data_n;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            sub_q       <= '0;
            ta_q        <= '0;
            wdata_q     <= '0;
            rdata_out_q <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            n_tsltsl_q  <= 1'b1;
            n_trd_q     <= 1'b1;
            n_twr_q     <= 1'b1;
        end else begin
            wr_q       <= wr_n;
            addr_q     <= addr_n;
            data_q     <= data_n;
            sub_q      <= sub_n;
            ta_q       <= ta_n;
            wdata_q    <= wdata_n;
            ready_q    <= (state_n == ST_IDLE);
            done_q     <= (state_n == ST_HOLD);
            n_tsltsl_q <= !((state_n == ST_STROBE) || (state_n == ST_SUB_STROBE));
            n_trd_q    <= !((state_n == ST_STROBE) && !wr_q);
            n_twr_q    <= !(((state_n == ST_STROBE) && wr_q) || (state_n == ST_SUB_STROBE));
            if ((state == ST_STROBE) && last && !wr_q) begin
                rdata_out_q <= bus.rdata_en ? bus.rdata : BUS_IDLE;
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.rdata_out = rdata_out_q;
    assign bus.n_tsltsl  = n_tsltsl_q;
    assign bus.n_trd     = n_trd_q;
    assign bus.n_twr     = n_twr_q;
    assign bus.ta        = ta_q;
    assign bus.wdata     = wdata_q;

endmodule

// File: tb/tb_msxbus_initiator.sv
// Directed bench for msxbus_initiator with STROBE_CYCLES=3, SUBSLOT_ADDR=FFFF.
module tb_msxbus_initiator;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    msxbus_initiator_if bus ();

    msxbus_initiator #(
        .STROBE_CYCLES(3),
        .SUBSLOT_ADDR (16'hFFFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample point: 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise a request in an IDLE/ready cycle; returns at the cycle-1 sample point.
    task automatic issue(input logic wr, input logic ext, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] s);
        bus.req_wr      = wr;
        bus.req_ext     = ext;
        bus.req_address = a;
        bus.req_wdata   = d;
        bus.req_subslot = s;
        bus.req         = 1'b1;
        step();
    endtask

    // Packed as {n_tsltsl, n_trd, n_twr, done, ready}.
    function automatic logic [4:0] pins();
        return {bus.n_tsltsl, bus.n_trd, bus.n_twr, bus.done, bus.ready};
    endfunction

    task automatic test_reset();
        logic [4:0] p;
        reset = 1'b1;
        step();
        step();
        p = pins();
        total++;
        if (p !== 5'b11100) begin
            bad++;
            $display("FAIL reset_pins: got %b want %b", p, 5'b11100);
        end
        total++;
        if (bus.ta !== 16'h0000 || bus.wdata !== 8'h00 || bus.rdata_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got ta=%h wdata=%h rdata_out=%h want 0000/00/00",
                     bus.ta, bus.wdata, bus.rdata_out);
        end
        reset = 1'b0;
        total++;
        if (bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_early: got %b want 0", bus.ready);
        end
        step();
        total++;
        if (bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise: got %b want 1", bus.ready);
        end
    endtask

    task automatic test_write();
        logic [4:0] e;
        logic [4:0] p;
        issue(1'b1, 1'b0, 16'h9800, 8'h5A, 8'h00);
        bus.req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 1)      e = 5'b11100;
            else if (k <= 4) e = 5'b01000;
            else if (k == 5) e = 5'b11110;
            else             e = 5'b11101;
            p = pins();
            total++;
            if (p !== e) begin
                bad++;
                $display("FAIL write_pins cyc%0d: got %b want %b", k, p, e);
            end
            if (k <= 5) begin
                total++;
                if (bus.ta !== 16'h9800 || bus.wdata !== 8'h5A) begin
                    bad++;
                    $display("FAIL write_bus cyc%0d: got ta=%h wdata=%h want 9800/5a",
                             k, bus.ta, bus.wdata);
                end
            end
            step();
        end
    endtask

    task automatic test_read();
        logic [4:0] e;
        logic [4:0] p;
        logic [7:0] want;
        bus.rdata = 8'h3C;
        for (int pass = 0; pass < 2; pass++) begin
            bus.rdata_en = (pass == 0);
            want = (pass == 0) ? 8'h3C : 8'hFF;
            issue(1'b0, 1'b0, 16'h9880, 8'h00, 8'h00);
            bus.req = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                if (k == 1)      e = 5'b11100;
                else if (k <= 4) e = 5'b00100;
                else if (k == 5) e = 5'b11110;
                else             e = 5'b11101;
                p = pins();
                total++;
                if (p !== e || bus.ta !== 16'h9880) begin
                    bad++;
                    $display("FAIL read%0d_pins cyc%0d: got %b ta=%h want %b ta=9880",
                             pass, k, p, bus.ta, e);
                end
                if (k == 2 && pass == 1) begin
                    total++;
                    if (bus.rdata_out !== 8'h3C) begin
                        bad++;
                        $display("FAIL read_hold: got %h want 3c", bus.rdata_out);
                    end
                end
                if (k >= 5) begin
                    total++;
                    if (bus.rdata_out !== want) begin
                        bad++;
                        $display("FAIL read%0d_data cyc%0d: got %h want %h",
                                 pass, k, bus.rdata_out, want);
                    end
                end
                step();
            end
        end
        bus.rdata_en = 1'b0;
    endtask

    // n_wait low on a non-final cycle (2) is ignored; low over 4..7 extends to 7 cycles.
    task automatic test_wait();
        logic [4:0] e;
        logic [4:0] p;
        bus.rdata_en = 1'b1;
        bus.rdata    = 8'h80;
        issue(1'b0, 1'b0, 16'h9880, 8'h00, 8'h00);
        bus.req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1)      e = 5'b11100;
            else if (k <= 8) e = 5'b00100;
            else if (k == 9) e = 5'b11110;
            else             e = 5'b11101;
            p = pins();
            total++;
            if (p !== e) begin
                bad++;
                $display("FAIL wait_pins cyc%0d: got %b want %b", k, p, e);
            end
            if (k == 9) begin
                total++;
                if (bus.rdata_out !== 8'h88) begin
                    bad++;
                    $display("FAIL wait_data: got %h want 88", bus.rdata_out);
                end
            end
            bus.n_wait = !((k == 2) || (k >= 4 && k <= 7));
            bus.rdata  = 8'h80 | 8'(k);
            step();
        end
        bus.n_wait   = 1'b1;
        bus.rdata_en = 1'b0;
    endtask

    task automatic test_ext();
        logic [4:0]  e;
        logic [4:0]  p;
        logic [15:0] ea;
        logic [7:0]  ed;
        issue(1'b1, 1'b1, 16'h4000, 8'h11, 8'h0C);
        bus.req = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k == 1 || k == 5 || k == 6)          e = 5'b11100;
            else if ((k >= 2 && k <= 4) || k <= 9)   e = 5'b01000;
            else if (k == 10)                        e = 5'b11110;
            else                                     e = 5'b11101;
            ea = (k <= 5) ? 16'hFFFF : 16'h4000;
            ed = (k <= 5) ? 8'h0C : 8'h11;
            p = pins();
            total++;
            if (p !== e) begin
                bad++;
                $display("FAIL ext_pins cyc%0d: got %b want %b", k, p, e);
            end
            if (k <= 10) begin
                total++;
                if (bus.ta !== ea || bus.wdata !== ed) begin
                    bad++;
                    $display("FAIL ext_bus cyc%0d: got ta=%h wdata=%h want %h/%h",
                             k, bus.ta, bus.wdata, ea, ed);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] p;
        issue(1'b1, 1'b0, 16'h1234, 8'h77, 8'h00);
        bus.req = 1'b0;
        step();
        step();
        p = pins();
        total++;
        if (p !== 5'b01000) begin
            bad++;
            $display("FAIL rstmid_pre: got %b want %b", p, 5'b01000);
        end
        #2;
        reset = 1'b1;
        #1;
        p = pins();
        total++;
        if (p !== 5'b11100 || bus.ta !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_async: got %b ta=%h want 11100 ta=0000", p, bus.ta);
        end
        step();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            p = pins();
            total++;
            if (p !== 5'b11101) begin
                bad++;
                $display("FAIL rstmid_after cyc%0d: got %b want %b", k, p, 5'b11101);
            end
        end
    endtask

    // With req held, the period is 6 cycles: SETUP, 3x STROBE, HOLD, IDLE.
    task automatic test_back_to_back();
        logic [4:0] e;
        logic [4:0] p;
        int         ph;
        issue(1'b1, 1'b0, 16'h2000, 8'h33, 8'h00);
        for (int k = 1; k <= 13; k++) begin
            ph = (k - 1) % 6;
            if (k == 13)     e = 5'b11101;
            else if (ph == 0) e = 5'b11100;
            else if (ph <= 3) e = 5'b01000;
            else if (ph == 4) e = 5'b11110;
            else              e = 5'b11101;
            p = pins();
            total++;
            if (p !== e) begin
                bad++;
                $display("FAIL b2b_pins cyc%0d: got %b want %b", k, p, e);
            end
            if (k == 12) bus.req = 1'b0;
            step();
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        bus.req         = 1'b0;
        bus.req_wr      = 1'b0;
        bus.req_ext     = 1'b0;
        bus.req_address = '0;
        bus.req_wdata   = '0;
        bus.req_subslot = '0;
        bus.rdata       = '0;
        bus.rdata_en    = 1'b0;
        bus.n_wait      = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_wait();
        test_ext();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
